// File: rtl/switch_debouncer_if.sv
// Switch-conditioning bus: raw switch inputs, debounced levels/pulses and
// the event FIFO handshake toward the CPU side.
interface switch_debouncer_if #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_level;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_levels;
  logic [WIDTH-1:0] evt_mask;
  logic [CW-1:0]    evt_count;
  logic             evt_overflow;
  logic             overflow_clear;

  modport slave (
    input  sw_in, evt_ready, overflow_clear,
    output sw_level, sw_rise, sw_fall, evt_valid, evt_levels, evt_mask,
           evt_count, evt_overflow
  );

  modport master (
    output sw_in, evt_ready, overflow_clear,
    input  sw_level, sw_rise, sw_fall, evt_valid, evt_levels, evt_mask,
           evt_count, evt_overflow
  );
endinterface

// File: rtl/switch_debouncer.sv
// Per-bit synchronizer + debounce counter, edge pulses, and a small event
// FIFO that records every debounced change as {levels, mask}.
module switch_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic               clk,
  input  logic               reset,
  switch_debouncer_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, fall_q;
  logic [WIDTH-1:0] change;

  // Pipeline stage so the event lands at the FIFO head one cycle after the level
  logic             push_q;
  logic [WIDTH-1:0] push_levels_q, push_mask_q;

  logic [WIDTH-1:0] mem_levels_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_mask_q   [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, not_empty, pop, wr, drop;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [15:0] cnt_q;
      logic        differ, done;

      assign differ        = sync2_q[gi] != level_q[gi];
      assign done          = differ && (cnt_q == CNT_MAX);
      assign level_d[gi]   = done ? sync2_q[gi] : level_q[gi];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          cnt_q <= '0;
        else if (!differ || done)
          cnt_q <= '0;
        else
          cnt_q <= cnt_q + 16'd1;
      end
    end
  endgenerate

  assign change = level_d ^ level_q;

  assign full      = count_q == CW'(FIFO_DEPTH);
  assign not_empty = count_q != '0;
  assign pop       = not_empty && bus.evt_ready;
  assign wr        = push_q && (!full || pop);
  assign drop      = push_q && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (drop)
      overflow_d = 1'b1;
    else if (bus.overflow_clear)
      overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      level_q       <= '0;
      rise_q        <= '0;
      fall_q        <= '0;
      push_q        <= 1'b0;
      push_levels_q <= '0;
      push_mask_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      sync1_q       <= bus.sw_in;
      sync2_q       <= sync1_q;
      level_q       <= level_d;
      rise_q        <= change & level_d;
      fall_q        <= change & ~level_d;
      push_q        <= |change;
      push_levels_q <= level_d;
      push_mask_q   <= change;
      if (wr)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q       <= count_d;
      overflow_q    <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_levels_q[wr_ptr_q] <= push_levels_q;
      mem_mask_q[wr_ptr_q]   <= push_mask_q;
    end
  end

  assign bus.sw_level     = level_q;
  assign bus.sw_rise      = rise_q;
  assign bus.sw_fall      = fall_q;
  assign bus.evt_valid    = not_empty;
  assign bus.evt_levels   = not_empty ? mem_levels_q[rd_ptr_q] : '0;
  assign bus.evt_mask     = not_empty ? mem_mask_q[rd_ptr_q] : '0;
  assign bus.evt_count    = count_q;
  assign bus.evt_overflow = overflow_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: reset behaviour, debounce latency,
// glitch rejection, event FIFO ordering, overflow and full push+pop.
module tb_switch_debouncer;
  localparam int W  = 4;
  localparam int D  = 3;
  localparam int FD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] seq_lv [4] = '{4'b1011, 4'b1001, 4'b1011, 4'b1001};

  always #5 clk = ~clk;

  switch_debouncer_if #(.WIDTH(W), .FIFO_DEPTH(FD)) bus ();

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " level"},    32'(bus.sw_level),     32'h0);
    chk({tag, " rise"},     32'(bus.sw_rise),      32'h0);
    chk({tag, " fall"},     32'(bus.sw_fall),      32'h0);
    chk({tag, " valid"},    32'(bus.evt_valid),    32'h0);
    chk({tag, " levels"},   32'(bus.evt_levels),   32'h0);
    chk({tag, " mask"},     32'(bus.evt_mask),     32'h0);
    chk({tag, " count"},    32'(bus.evt_count),    32'h0);
    chk({tag, " overflow"}, 32'(bus.evt_overflow), 32'h0);
  endtask

  // Drive a new stable input and follow it through the D+2 cycle latency.
  task automatic apply(input logic [3:0] nv, input int cnt_at_change,
                       input int cnt_after, input string tag);
    logic [3:0] old;
    old = bus.sw_level;
    bus.sw_in = nv;
    repeat (4) begin
      tick;
      chk({tag, " hold"}, 32'(bus.sw_level), 32'(old));
    end
    tick;
    chk({tag, " level"},  32'(bus.sw_level),  32'(nv));
    chk({tag, " rise"},   32'(bus.sw_rise),   32'(nv & ~old));
    chk({tag, " fall"},   32'(bus.sw_fall),   32'(old & ~nv));
    chk({tag, " cnt0"},   32'(bus.evt_count), 32'(cnt_at_change));
    tick;
    chk({tag, " rise1"},  32'(bus.sw_rise),   32'h0);
    chk({tag, " fall1"},  32'(bus.sw_fall),   32'h0);
    chk({tag, " cnt1"},   32'(bus.evt_count), 32'(cnt_after));
  endtask

  task automatic pop_head(input logic [3:0] lv, input logic [3:0] mk, input string tag);
    chk({tag, " valid"},  32'(bus.evt_valid),  32'h1);
    chk({tag, " levels"}, 32'(bus.evt_levels), 32'(lv));
    chk({tag, " mask"},   32'(bus.evt_mask),   32'(mk));
    bus.evt_ready = 1'b1;
    tick;
    bus.evt_ready = 1'b0;
  endtask

  initial begin
    bus.sw_in          = 4'b0101;
    bus.evt_ready      = 1'b0;
    bus.overflow_clear = 1'b0;
    #2 reset = 1'b0;
    repeat (2) tick;
    chk_idle("in_reset");
    reset = 1'b1;

    // Held switch after release: 4 cycles at 0, then 0101 with a rise pulse
    apply(4'b0101, 0, 1, "rst_rise");
    pop_head(4'b0101, 4'b0101, "ev_rst");
    chk("empty_valid", 32'(bus.evt_valid), 32'h0);
    chk("empty_count", 32'(bus.evt_count), 32'h0);
    $display("step: release rise checked");

    apply(4'b0000, 0, 1, "fall_all");
    pop_head(4'b0000, 4'b0101, "ev_fall");
    $display("step: fall checked");

    // 2-cycle glitch on bit 2 must be rejected
    bus.sw_in = 4'b0100;
    repeat (2) tick;
    bus.sw_in = 4'b0000;
    repeat (8) begin
      tick;
      chk("glitch level", 32'(bus.sw_level),  32'h0);
      chk("glitch rise",  32'(bus.sw_rise),   32'h0);
      chk("glitch count", 32'(bus.evt_count), 32'h0);
    end
    $display("step: glitch rejected");

    // 3-cycle pulse on bit 2 is just long enough
    bus.sw_in = 4'b0100;
    repeat (3) tick;
    bus.sw_in = 4'b0000;
    tick;
    chk("p3 level_e4", 32'(bus.sw_level), 32'h0);
    tick;
    chk("p3 level_e5", 32'(bus.sw_level), 32'h4);
    chk("p3 rise_e5",  32'(bus.sw_rise),  32'h4);
    tick;
    chk("p3 rise_e6",  32'(bus.sw_rise),  32'h0);
    chk("p3 count_e6", 32'(bus.evt_count), 32'h1);
    tick;
    chk("p3 level_e7", 32'(bus.sw_level), 32'h4);
    chk("p3 fall_e7",  32'(bus.sw_fall),  32'h0);
    tick;
    chk("p3 level_e8", 32'(bus.sw_level), 32'h0);
    chk("p3 fall_e8",  32'(bus.sw_fall),  32'h4);
    tick;
    chk("p3 count_e9", 32'(bus.evt_count), 32'h2);
    chk("p3 head0 lv", 32'(bus.evt_levels), 32'h4);
    chk("p3 head0 mk", 32'(bus.evt_mask),   32'h4);
    bus.evt_ready = 1'b1;
    tick;
    chk("p3 head1 lv", 32'(bus.evt_levels), 32'h0);
    chk("p3 head1 mk", 32'(bus.evt_mask),   32'h4);
    chk("p3 count1",   32'(bus.evt_count),  32'h1);
    tick;
    bus.evt_ready = 1'b0;
    chk("p3 valid_end", 32'(bus.evt_valid), 32'h0);
    chk("p3 count_end", 32'(bus.evt_count), 32'h0);
    $display("step: 3-cycle pulse checked");

    apply(4'b1001, 0, 1, "bits03");
    pop_head(4'b1001, 4'b1001, "ev_bits03");
    $display("step: simultaneous bits checked");

    // Five changes with no consumer: fifth is dropped
    apply(4'b1011, 0, 1, "ovf1");
    apply(4'b1001, 1, 2, "ovf2");
    apply(4'b1011, 2, 3, "ovf3");
    apply(4'b1001, 3, 4, "ovf4");
    chk("ovf before", 32'(bus.evt_overflow), 32'h0);
    apply(4'b1011, 4, 4, "ovf5");
    chk("ovf set",   32'(bus.evt_overflow), 32'h1);
    chk("ovf count", 32'(bus.evt_count),    32'h4);
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf pop lv", 32'(bus.evt_levels), 32'(seq_lv[i]));
      chk("ovf pop mk", 32'(bus.evt_mask),   32'h2);
      tick;
    end
    bus.evt_ready = 1'b0;
    chk("ovf drained", 32'(bus.evt_valid),    32'h0);
    chk("ovf sticky",  32'(bus.evt_overflow), 32'h1);
    bus.overflow_clear = 1'b1;
    tick;
    bus.overflow_clear = 1'b0;
    chk("ovf cleared", 32'(bus.evt_overflow), 32'h0);
    $display("step: overflow checked");

    // Full FIFO with push and pop on the same edge
    apply(4'b1001, 0, 1, "full1");
    apply(4'b1011, 1, 2, "full2");
    apply(4'b1001, 2, 3, "full3");
    apply(4'b1011, 3, 4, "full4");
    bus.sw_in = 4'b1001;
    repeat (5) tick;
    chk("fpp level", 32'(bus.sw_level),  32'h9);
    chk("fpp count", 32'(bus.evt_count), 32'h4);
    bus.evt_ready = 1'b1;
    tick;
    chk("fpp count_after", 32'(bus.evt_count),    32'h4);
    chk("fpp overflow",    32'(bus.evt_overflow), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("fpp pop lv", 32'(bus.evt_levels), 32'(seq_lv[i]));
      chk("fpp pop mk", 32'(bus.evt_mask),   32'h2);
      tick;
    end
    bus.evt_ready = 1'b0;
    chk("fpp drained", 32'(bus.evt_valid), 32'h0);
    $display("step: full push+pop checked");

    // Reset with two queued events and bit 1 mid-count
    apply(4'b1011, 0, 1, "pre_rst1");
    apply(4'b1001, 1, 2, "pre_rst2");
    bus.sw_in = 4'b1011;
    repeat (3) tick;
    reset = 1'b0;
    #1;
    chk_idle("reset_async");
    tick;
    tick;
    chk_idle("reset_hold");
    reset = 1'b1;
    apply(4'b1011, 0, 1, "post_rst");
    pop_head(4'b1011, 4'b1011, "ev_post_rst");
    chk("post_rst empty", 32'(bus.evt_count), 32'h0);
    $display("step: mid-operation reset checked");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
